// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
//
// Holds the fetch PC, issues one word read at a time to instruction memory
// over a req/ack handshake, and keeps up to two fetched instructions in a
// small FIFO whose registered head is presented to decode.  A redirect
// flushes the FIFO and retargets fetch.  If a request is still waiting for
// its ack, the unit first drains that request and then moves to the target.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   imem_req     read request to instruction memory
//   imem_addr    word address of the request, held until ack
//   imem_ack     request accepted, imem_data valid in the same cycle
//   imem_data    instruction word returned with imem_ack
//   stall        decode cannot accept an instruction this cycle
//   redirect     taken branch/jump, single-cycle pulse
//   redirect_pc  new fetch target, valid with redirect
//   inst         instruction at the buffer head
//   inst_pc      word address of inst
//   inst_valid   inst/inst_pc are valid
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic        inst_valid
);

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [1:0] FULL = 2'(DEPTH);

  state_t      state, state_next;
  logic [15:0] fetch_pc, fetch_pc_next;
  logic [15:0] target_pc, target_pc_next;
  logic [1:0]  count;
  logic        started;
  logic        push, pop;

  // Two-entry FIFO: head is what decode sees, tail is the younger entry.
  logic [15:0] head_inst, head_pc;
  logic [15:0] tail_inst, tail_pc;

  assign inst       = head_inst;
  assign inst_pc    = head_pc;
  assign inst_valid = (count != 2'd0);
  // In DRAIN fetch_pc has not moved yet, so the pending address stays put.
  assign imem_addr  = fetch_pc;

  always_comb begin
    state_next     = state;
    fetch_pc_next  = fetch_pc;
    target_pc_next = target_pc;
    imem_req       = 1'b0;
    unique case (state)
      FETCH: begin
        // started keeps req low for the first cycle after reset release.
        imem_req = started && (count != FULL);
        if (redirect) begin
          if (imem_req && !imem_ack) begin
            // Request is in flight: it must complete before retargeting.
            target_pc_next = redirect_pc;
            state_next     = DRAIN;
          end else begin
            fetch_pc_next = redirect_pc;
          end
        end else if (imem_req && imem_ack) begin
          fetch_pc_next = fetch_pc + 16'd1;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          // Drained word is dropped; a redirect arriving with the ack wins.
          state_next    = FETCH;
          fetch_pc_next = redirect ? redirect_pc : target_pc;
        end else if (redirect) begin
          target_pc_next = redirect_pc;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign push = (state == FETCH) && imem_req && imem_ack && !redirect;
  assign pop  = inst_valid && !stall && !redirect;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      fetch_pc  <= RESET_PC;
      target_pc <= RESET_PC;
      started   <= 1'b0;
      count     <= 2'd0;
      head_inst <= 16'h0000;
      head_pc   <= 16'h0000;
      tail_inst <= 16'h0000;
      tail_pc   <= 16'h0000;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      target_pc <= target_pc_next;
      started   <= 1'b1;
      if (redirect) begin
        // Flush only clears the count; head keeps its last values.
        count <= 2'd0;
      end else begin
        unique case ({push, pop})
          2'b10: begin
            count <= count + 2'd1;
            if (count == 2'd0) begin
              head_inst <= imem_data;
              head_pc   <= fetch_pc;
            end else begin
              tail_inst <= imem_data;
              tail_pc   <= fetch_pc;
            end
          end
          2'b01: begin
            count <= count - 2'd1;
            // Popping the last entry leaves the head holding stale values.
            if (count == 2'd2) begin
              head_inst <= tail_inst;
              head_pc   <= tail_pc;
            end
          end
          2'b11: begin
            if (count == 2'd1) begin
              head_inst <= imem_data;
              head_pc   <= fetch_pc;
            end else begin
              head_inst <= tail_inst;
              head_pc   <= tail_pc;
              tail_inst <= imem_data;
              tail_pc   <= fetch_pc;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the instruction decoder. Keeps the fetch PC and issues word reads to instruction memory over a req/ack handshake. Buffers up to two fetched 16-bit instructions and presents the oldest one, with its PC, to decode. Supports downstream stall and a branch/jump redirect that flushes in-flight work.

Parameters:
RESET_PC, 16'h0000, fetch PC value loaded on reset.
DEPTH, 2, instruction buffer entries; fixed at 2, other values unsupported.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
imem_req  output  1  read request to instruction memory
imem_addr  output  16  word address of request; stable while imem_req high until ack
imem_ack  input  1  request accepted; imem_data valid this same cycle
imem_data  input  16  instruction word returned with imem_ack
stall  input  1  decode cannot accept this cycle
redirect  input  1  taken branch/jump; 1-cycle pulse
redirect_pc  input  16  new fetch target, valid with redirect
inst  output  16  instruction to decode (buffer head)
inst_pc  output  16  word address of inst
inst_valid  output  1  inst/inst_pc valid

Behaviour:
- Reset (rst_n low at edge): state=FETCH, fetch_pc=RESET_PC, buffer count=0.
- Reset values: imem_req=0, imem_addr=RESET_PC, inst=0, inst_pc=0, inst_valid=0.
- Reset mid-transaction abandons any outstanding request. Memory must tolerate req dropping without ack on reset only.
- First imem_req rises the cycle after rst_n is seen high.
- Buffer: 2-entry FIFO of {inst, pc}. inst/inst_pc/inst_valid come from registered head, no combinational path from imem_data.
- Pop when inst_valid & ~stall. Push when imem_ack & state==FETCH & ~redirect.
- Simultaneous push+pop: count unchanged, order preserved.
- States:
  - FETCH: imem_req = (count<2); imem_addr=fetch_pc. On ack: fetch_pc<=fetch_pc+1, modulo 2^16, so 16'hFFFF wraps to 16'h0000.
  - DRAIN: imem_req=1; imem_addr holds the old address until ack. On ack the data is discarded, fetch_pc<=pending target, and state goes to FETCH.
- One outstanding request at most. Count only rises on ack, so imem_req never drops while unacked except on redirect or reset.
- Back-to-back acks give 1 instruction/cycle when stall=0.
- Redirect (priority over push/pop):
  - Buffer flushes to count=0. inst_valid=0 the next cycle; a pop in the redirect cycle has no effect on the result.
  - If imem_req high and imem_ack low: target latched, state goes to DRAIN.
  - If imem_ack high the same cycle: that data is discarded, fetch_pc<=redirect_pc, and state stays FETCH.
  - If imem_req low: fetch_pc<=redirect_pc, state stays FETCH.
  - Redirect while in DRAIN: latched target is replaced by the new redirect_pc, and state stays DRAIN.
- First redirected instruction reaches inst_valid no earlier than 2 cycles after redirect, given a zero-wait ack.
- Full (count=2) with stall=1: imem_req=0 and outputs hold stable.
- Empty: inst_valid=0; inst/inst_pc hold their last values.

Test Plan:
- Reset, then ack every cycle returning data=addr^16'hA5A5, stall=0 -> first req at addr 0x0000 the cycle after reset; inst_valid stream of pc 0,1,2,… with one instruction per cycle.
- Ack every cycle, stall=1 from cycle 3 -> count reaches 2, imem_req drops, inst/inst_pc frozen. Release stall -> pcs continue with no gap or duplicate.
- Redirect to 0x0100 with req high, ack delayed 3 cycles -> imem_addr holds old value until ack, that data never appears, next req addr=0x0100, inst_pc=0x0100 next valid.
- Redirect to 0x0200 coincident with ack -> acked word discarded, next imem_addr=0x0200, no DRAIN cycle.
- RESET_PC=16'hFFFE, continuous ack -> inst_pc sequence FFFE, FFFF, 0000, 0001.
- rst_n low during DRAIN with 1 buffered entry -> next cycle imem_req=0, inst_valid=0, imem_addr=RESET_PC, and fetch restarts cleanly.
